// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl
//   Sequencer for the convolution window buffer. On start it walks the output
//   feature map in raster order. For each output pixel it loads the window
//   (LOAD), steps buf_l/buf_c across the kernel while accumulating
//   img_cal*wei_cal (MAC), and presents the dot product on a valid/ready port
//   (OUT). After the last handshake it pulses done (DONE) and returns to IDLE.
//
// Ports
//   clk_en        sole clock, rising edge
//   rst           asynchronous active-high reset
//   start         begin one feature map (sampled only in IDLE)
//   busy          high in every state except IDLE
//   done          one-cycle pulse after the final result handshake
//   conv_on       window buffer load enable (LOAD and MAC)
//   anchor_l/c    window top-left in padded coordinates (out index * stride)
//   buf_l/c       kernel row/column selected in the buffer
//   img_cal       selected image element (valid from the first MAC cycle)
//   wei_cal       selected weight element
//   result        window sum of products
//   result_valid  result available; result_ready accepts it
//   result_l/c    output row/column index of result
module conv_window_ctrl #(
  parameter int weight_width  = 2,
  parameter int weight_height = 2,
  parameter int img_width     = 4,
  parameter int img_height    = 4,
  parameter int padding       = 0,
  parameter int stride        = 1,
  parameter int bitwidth      = 3,
  parameter int result_width  = (img_width - weight_width + 2*padding)/stride + 1,
  parameter int result_height = (img_height - weight_height + 2*padding)/stride + 1,
  parameter int acc_width     = 2*bitwidth + $clog2(weight_width*weight_height)
) (
  input  logic                 clk_en,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 conv_on,
  output logic [31:0]          anchor_l,
  output logic [31:0]          anchor_c,
  output logic [3:0]           buf_l,
  output logic [3:0]           buf_c,
  input  logic [bitwidth-1:0]  img_cal,
  input  logic [bitwidth-1:0]  wei_cal,
  output logic [acc_width-1:0] result,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [15:0]          result_l,
  output logic [15:0]          result_c
);

  localparam int          PROD_W   = 2*bitwidth;
  localparam logic [3:0]  KC_LAST  = 4'(weight_width - 1);
  localparam logic [3:0]  KL_LAST  = 4'(weight_height - 1);
  localparam logic [15:0] COL_LAST = 16'(result_width - 1);
  localparam logic [15:0] ROW_LAST = 16'(result_height - 1);
  localparam logic [31:0] STRIDE_W = 32'(stride);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_OUT,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [15:0]            row_q, row_d;
  logic [15:0]            col_q, col_d;
  logic [3:0]             bl_q, bl_d;
  logic [3:0]             bc_q, bc_d;
  logic [acc_width-1:0]   acc_q, acc_d;
  logic [acc_width-1:0]   res_q, res_d;
  logic                   rv_q, rv_d;
  logic [15:0]            rl_q, rl_d;
  logic [15:0]            rc_q, rc_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   conv_q, conv_d;
  logic [31:0]            al_q, al_d;
  logic [31:0]            ac_q, ac_d;

  logic [PROD_W-1:0]      prod;
  logic [acc_width-1:0]   acc_sum;

  always_comb begin
    prod    = PROD_W'(img_cal) * PROD_W'(wei_cal);
    acc_sum = acc_q + acc_width'(prod);

    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    bl_d    = bl_q;
    bc_d    = bc_q;
    acc_d   = acc_q;
    res_d   = res_q;
    rv_d    = rv_q;
    rl_d    = rl_q;
    rc_d    = rc_q;
    al_d    = al_q;
    ac_d    = ac_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_LOAD: begin
        state_d = S_MAC;
        acc_d   = '0;
        bl_d    = '0;
        bc_d    = '0;
      end
      S_MAC: begin
        acc_d = acc_sum;
        if (bc_q == KC_LAST) begin
          bc_d = '0;
          if (bl_q == KL_LAST) begin
            // Last kernel element: the finished sum goes straight into the
            // output register so result is stable for the whole OUT phase.
            state_d = S_OUT;
            bl_d    = '0;
            res_d   = acc_sum;
            rv_d    = 1'b1;
            rl_d    = row_q;
            rc_d    = col_q;
          end else begin
            bl_d = bl_q + 4'd1;
          end
        end else begin
          bc_d = bc_q + 4'd1;
        end
      end
      S_OUT: begin
        if (result_ready) begin
          rv_d = 1'b0;
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              state_d = S_DONE;
            end else begin
              row_d   = row_q + 16'd1;
              state_d = S_LOAD;
            end
          end else begin
            col_d   = col_q + 16'd1;
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the next state and
    // next counters; the anchor only moves when a new window is loaded.
    conv_d = (state_d == S_LOAD) || (state_d == S_MAC);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    if (state_d == S_LOAD) begin
      al_d = 32'(row_d) * STRIDE_W;
      ac_d = 32'(col_d) * STRIDE_W;
    end
  end

  always_ff @(posedge clk_en or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      bl_q    <= '0;
      bc_q    <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      rv_q    <= 1'b0;
      rl_q    <= '0;
      rc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      conv_q  <= 1'b0;
      al_q    <= '0;
      ac_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      bl_q    <= bl_d;
      bc_q    <= bc_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
      rl_q    <= rl_d;
      rc_q    <= rc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      conv_q  <= conv_d;
      al_q    <= al_d;
      ac_q    <= ac_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign conv_on      = conv_q;
  assign anchor_l     = al_q;
  assign anchor_c     = ac_q;
  assign buf_l        = bl_q;
  assign buf_c        = bc_q;
  assign result       = res_q;
  assign result_valid = rv_q;
  assign result_l     = rl_q;
  assign result_c     = rc_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Testbench for conv_window_ctrl: three instances (basic 2x2 stride 1,
// 2x2 stride 2, 3x3 with padding 1) share one clock and reset. A small
// window-buffer model feeds img_cal from the 4x4 image holding 0..15.
module tb_conv_window_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int wsel_g   = 0;

  logic        start_s [3];
  logic        rdy_s   [3];
  logic        busy_w  [3];
  logic        done_w  [3];
  logic        conv_w  [3];
  logic        rv_w    [3];
  logic [31:0] al_w    [3];
  logic [31:0] ac_w    [3];
  logic [3:0]  bl_w    [3];
  logic [3:0]  bc_w    [3];
  logic [15:0] rl_w    [3];
  logic [15:0] rc_w    [3];
  logic [7:0]  img_w   [3];
  logic [7:0]  wei_w   [3];
  logic [19:0] res_w   [3];
  logic [17:0] res0, res1;
  logic [19:0] res2;

  always_comb begin
    res_w[0] = 20'(res0);
    res_w[1] = 20'(res1);
    res_w[2] = res2;
  end

  conv_window_ctrl #(.weight_width(2), .weight_height(2), .img_width(4), .img_height(4),
                     .padding(0), .stride(1), .bitwidth(8)) u_basic (
    .clk_en(clk), .rst(rst), .start(start_s[0]), .busy(busy_w[0]), .done(done_w[0]),
    .conv_on(conv_w[0]), .anchor_l(al_w[0]), .anchor_c(ac_w[0]), .buf_l(bl_w[0]),
    .buf_c(bc_w[0]), .img_cal(img_w[0]), .wei_cal(wei_w[0]), .result(res0),
    .result_valid(rv_w[0]), .result_ready(rdy_s[0]), .result_l(rl_w[0]), .result_c(rc_w[0]));

  conv_window_ctrl #(.weight_width(2), .weight_height(2), .img_width(4), .img_height(4),
                     .padding(0), .stride(2), .bitwidth(8)) u_stride (
    .clk_en(clk), .rst(rst), .start(start_s[1]), .busy(busy_w[1]), .done(done_w[1]),
    .conv_on(conv_w[1]), .anchor_l(al_w[1]), .anchor_c(ac_w[1]), .buf_l(bl_w[1]),
    .buf_c(bc_w[1]), .img_cal(img_w[1]), .wei_cal(wei_w[1]), .result(res1),
    .result_valid(rv_w[1]), .result_ready(rdy_s[1]), .result_l(rl_w[1]), .result_c(rc_w[1]));

  conv_window_ctrl #(.weight_width(3), .weight_height(3), .img_width(4), .img_height(4),
                     .padding(1), .stride(1), .bitwidth(8)) u_pad (
    .clk_en(clk), .rst(rst), .start(start_s[2]), .busy(busy_w[2]), .done(done_w[2]),
    .conv_on(conv_w[2]), .anchor_l(al_w[2]), .anchor_c(ac_w[2]), .buf_l(bl_w[2]),
    .buf_c(bc_w[2]), .img_cal(img_w[2]), .wei_cal(wei_w[2]), .result(res2),
    .result_valid(rv_w[2]), .result_ready(rdy_s[2]), .result_l(rl_w[2]), .result_c(rc_w[2]));

  // Window buffer model: latches the anchor while conv_on, then serves the
  // padded-coordinate element selected by buf_l/buf_c (zero outside image).
  localparam int PADS [3] = '{0, 0, 1};
  int al_q [3] = '{0, 0, 0};
  int ac_q [3] = '{0, 0, 0};

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (conv_w[d]) begin
        al_q[d] <= int'(al_w[d]);
        ac_q[d] <= int'(ac_w[d]);
      end
    end
  end

  function automatic logic [7:0] pix(input int i, input int j);
    if (i < 0 || i > 3 || j < 0 || j > 3) return 8'd0;
    return 8'(4*i + j);
  endfunction

  always_comb begin
    for (int d = 0; d < 3; d++) begin
      img_w[d] = pix(al_q[d] + int'(bl_w[d]) - PADS[d], ac_q[d] + int'(bc_w[d]) - PADS[d]);
      // Alternate basic kernel [1 2; 3 4] when wsel_g is set, else all ones.
      wei_w[d] = (d == 0 && wsel_g != 0) ? 8'(2*int'(bl_w[d]) + int'(bc_w[d]) + 1) : 8'd1;
    end
  end

  // Hand-computed expected results, raster order.
  localparam int EXP_B [9]  = '{10, 14, 18, 26, 30, 34, 42, 46, 50};
  localparam int EXP_W [9]  = '{34, 44, 54, 74, 84, 94, 114, 124, 134};
  localparam int EXP_S [4]  = '{10, 18, 42, 50};
  localparam int EXP_P [16] = '{10, 18, 24, 18, 27, 45, 54, 39,
                                51, 81, 90, 63, 42, 66, 72, 50};

  function automatic int exp_of(input int d, input int wsel, input int idx);
    if (d == 0 && idx < 9) return (wsel != 0) ? EXP_W[idx] : EXP_B[idx];
    if (d == 1 && idx < 4) return EXP_S[idx];
    if (d == 2 && idx < 16) return EXP_P[idx];
    return -1;
  endfunction

  // Runs one full map on instance d; start is driven for cycle 0, so cycle k
  // is the k-th negedge after that. Optional backpressure on the first result
  // and an optional start re-pulse at cycle extra_start while busy.
  task automatic run_map(input int d, input int wsel, input int bp, input int extra_start,
                         input int rw, input int rh, input int strd, input int exp_done);
    int   idx, win, bp_cnt;
    logic prev_conv, fin;
    idx = 0; win = 0; bp_cnt = 0; prev_conv = 1'b0; fin = 1'b0;
    wsel_g = wsel;
    rdy_s[d] = 1'b1;
    start_s[d] = 1'b1;
    for (int k = 1; k <= exp_done + 20 && !fin; k++) begin
      @(negedge clk);
      start_s[d] = (k == extra_start);
      if (conv_w[d] && !prev_conv) begin
        checks++;
        if (al_w[d] !== 32'((win / rw) * strd) || ac_w[d] !== 32'((win % rw) * strd) ||
            bl_w[d] !== 4'd0 || bc_w[d] !== 4'd0) begin
          failures++;
          $display("FAIL load_anchor dut%0d win%0d: got l=%0d c=%0d bl=%0d bc=%0d expected l=%0d c=%0d bl=0 bc=0",
                   d, win, al_w[d], ac_w[d], bl_w[d], bc_w[d], (win / rw) * strd, (win % rw) * strd);
        end
        win++;
      end
      prev_conv = conv_w[d];
      if (rv_w[d]) begin
        if (bp_cnt < bp) begin
          bp_cnt++;
          rdy_s[d] = 1'b0;
          checks++;
          if (res_w[d] !== 20'(exp_of(d, wsel, idx)) || rl_w[d] !== 16'(idx / rw) ||
              rc_w[d] !== 16'(idx % rw) || conv_w[d] !== 1'b0 ||
              al_w[d] !== 32'(((win - 1) / rw) * strd) || ac_w[d] !== 32'(((win - 1) % rw) * strd)) begin
            failures++;
            $display("FAIL backpressure_hold dut%0d cyc%0d: got res=%0d l=%0d c=%0d conv=%0d al=%0d ac=%0d expected res=%0d l=%0d c=%0d conv=0 al=%0d ac=%0d",
                     d, k, res_w[d], rl_w[d], rc_w[d], conv_w[d], al_w[d], ac_w[d],
                     exp_of(d, wsel, idx), idx / rw, idx % rw,
                     ((win - 1) / rw) * strd, ((win - 1) % rw) * strd);
          end
        end else begin
          rdy_s[d] = 1'b1;
          checks++;
          if (res_w[d] !== 20'(exp_of(d, wsel, idx)) || rl_w[d] !== 16'(idx / rw) ||
              rc_w[d] !== 16'(idx % rw) || conv_w[d] !== 1'b0) begin
            failures++;
            $display("FAIL result dut%0d idx%0d: got res=%0d l=%0d c=%0d conv=%0d expected res=%0d l=%0d c=%0d conv=0",
                     d, idx, res_w[d], rl_w[d], rc_w[d], conv_w[d],
                     exp_of(d, wsel, idx), idx / rw, idx % rw);
          end
          idx++;
        end
      end else begin
        rdy_s[d] = 1'b1;
      end
      if (done_w[d]) begin
        checks++;
        if (k != exp_done || idx != rw * rh || busy_w[d] !== 1'b1) begin
          failures++;
          $display("FAIL done_timing dut%0d: got cycle=%0d results=%0d busy=%0d expected cycle=%0d results=%0d busy=1",
                   d, k, idx, busy_w[d], exp_done, rw * rh);
        end
        fin = 1'b1;
      end
    end
    start_s[d] = 1'b0;
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL done_timeout dut%0d: got no done, expected done at cycle %0d", d, exp_done);
    end
    @(negedge clk);
    checks++;
    if (busy_w[d] !== 1'b0 || done_w[d] !== 1'b0) begin
      failures++;
      $display("FAIL busy_fall dut%0d: got busy=%0d done=%0d expected busy=0 done=0",
               d, busy_w[d], done_w[d]);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (busy_w[d] !== 1'b0 || done_w[d] !== 1'b0 || conv_w[d] !== 1'b0 || rv_w[d] !== 1'b0 ||
          al_w[d] !== '0 || ac_w[d] !== '0 || bl_w[d] !== '0 || bc_w[d] !== '0 ||
          res_w[d] !== '0 || rl_w[d] !== '0 || rc_w[d] !== '0) begin
        failures++;
        $display("FAIL reset_state dut%0d: got busy=%0d done=%0d conv=%0d rv=%0d al=%0d ac=%0d bl=%0d bc=%0d res=%0d l=%0d c=%0d expected all 0",
                 d, busy_w[d], done_w[d], conv_w[d], rv_w[d], al_w[d], ac_w[d], bl_w[d], bc_w[d],
                 res_w[d], rl_w[d], rc_w[d]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // 9 windows of 1 LOAD + 4 MAC + 1 OUT occupy cycles 1..54; DONE in cycle 55,
  // i.e. the 56th cycle counting the start cycle.
  task automatic test_basic();
    run_map(0, 0, 0, -1, 3, 3, 1, 55);
  endtask

  task automatic test_weights();
    run_map(0, 1, 0, -1, 3, 3, 1, 55);
  endtask

  task automatic test_stride();
    run_map(1, 0, 0, -1, 2, 2, 2, 25);
  endtask

  task automatic test_backpressure();
    run_map(0, 0, 5, -1, 3, 3, 1, 60);
  endtask

  // 16 windows of 1 LOAD + 9 MAC + 1 OUT occupy cycles 1..176; DONE in 177.
  task automatic test_padding();
    run_map(2, 0, 0, -1, 4, 4, 1, 177);
  endtask

  task automatic test_reset_midrun();
    logic bad;
    wsel_g = 0;
    rdy_s[0] = 1'b1;
    start_s[0] = 1'b1;
    // Third window: LOAD in cycle 13, MAC in cycles 14..17.
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start_s[0] = 1'b0;
    end
    checks++;
    if (conv_w[0] !== 1'b1 || busy_w[0] !== 1'b1 || rv_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL midrun_mac dut0: got conv=%0d busy=%0d rv=%0d expected conv=1 busy=1 rv=0",
               conv_w[0], busy_w[0], rv_w[0]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || conv_w[0] !== 1'b0 || rv_w[0] !== 1'b0 ||
        al_w[0] !== '0 || ac_w[0] !== '0 || bl_w[0] !== '0 || bc_w[0] !== '0 ||
        res_w[0] !== '0 || rl_w[0] !== '0 || rc_w[0] !== '0) begin
      failures++;
      $display("FAIL async_reset dut0: got busy=%0d done=%0d conv=%0d rv=%0d al=%0d ac=%0d bl=%0d bc=%0d res=%0d l=%0d c=%0d expected all 0",
               busy_w[0], done_w[0], conv_w[0], rv_w[0], al_w[0], ac_w[0], bl_w[0], bc_w[0],
               res_w[0], rl_w[0], rc_w[0]);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || rv_w[0] !== 1'b0 || conv_w[0] !== 1'b0)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL post_reset_idle dut0: got activity without start, expected busy=done=rv=conv=0");
    end
    // Fresh run with a stray start pulse in cycle 10 while busy.
    run_map(0, 0, 0, 10, 3, 3, 1, 55);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      start_s[d] = 1'b0;
      rdy_s[d]   = 1'b1;
    end
    test_reset();
    test_basic();
    test_weights();
    test_stride();
    test_backpressure();
    test_padding();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
